// File: rtl/mor1kx_dpram_fifo_pkg.sv
// Shared defaults and sizing helper for the dual-port-RAM backed FWFT FIFO.
package mor1kx_dpram_fifo_pkg;

   localparam int unsigned FIFO_DEPTH_WIDTH = 4;
   localparam int unsigned FIFO_DATA_WIDTH  = 32;

   // RAM entries plus the output register.
   function automatic int unsigned fifo_capacity(input int unsigned depth_width);
      return (32'd1 << depth_width) + 32'd1;
   endfunction

endpackage

// File: rtl/mor1kx_dpram_fifo_ram.sv
// Single-clock true dual-port RAM, read-before-write, registered read data on both ports.
module mor1kx_dpram_fifo_ram #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  we_a_i,
   input  logic [ADDR_WIDTH-1:0] addr_a_i,
   input  logic [DATA_WIDTH-1:0] din_a_i,
   output logic [DATA_WIDTH-1:0] dout_a_o,
   input  logic                  we_b_i,
   input  logic [ADDR_WIDTH-1:0] addr_b_i,
   input  logic [DATA_WIDTH-1:0] din_b_i,
   output logic [DATA_WIDTH-1:0] dout_b_o
);

   localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_a_i) mem_q[addr_a_i] <= din_a_i;
      if (we_b_i) mem_q[addr_b_i] <= din_b_i;
      dout_a_o <= mem_q[addr_a_i];
      dout_b_o <= mem_q[addr_b_i];
   end

endmodule

// File: rtl/mor1kx_dpram_fifo.sv
// First-word-fall-through FIFO: RAM body, output head register and a
// write/prefetch collision bypass so rd_data_o is valid whenever empty_o is low.
module mor1kx_dpram_fifo
   import mor1kx_dpram_fifo_pkg::*;
#(
   parameter int unsigned DEPTH_WIDTH = FIFO_DEPTH_WIDTH,
   parameter int unsigned DATA_WIDTH  = FIFO_DATA_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush_i,
   input  logic                   wr_i,
   input  logic [DATA_WIDTH-1:0]  wr_data_i,
   output logic                   full_o,
   input  logic                   rd_i,
   output logic [DATA_WIDTH-1:0]  rd_data_o,
   output logic                   empty_o,
   output logic [DEPTH_WIDTH:0]   count_o
);

   localparam int unsigned CNT_WIDTH = DEPTH_WIDTH + 1;
   localparam int unsigned CAPACITY  = fifo_capacity(DEPTH_WIDTH);

   logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0]   ram_cnt_q, ram_cnt_d;
   logic                   out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
   logic                   byp_valid_q, byp_valid_d;
   logic [DATA_WIDTH-1:0]  byp_data_q, byp_data_d;

   logic                   push, pop, refill, ram_take, fall_thru, ram_we;
   logic [DEPTH_WIDTH-1:0] rd_ptr_next;
   logic [DATA_WIDTH-1:0]  ram_dout_b;

   assign count_o   = ram_cnt_q + CNT_WIDTH'(out_valid_q);
   assign full_o    = (count_o == CNT_WIDTH'(CAPACITY));
   assign empty_o   = ~out_valid_q;
   assign rd_data_o = out_data_q;

   // Head refill, RAM write and bypass capture; flush overrides everything.
   always_comb begin
      push        = wr_i & ~full_o;
      pop         = rd_i & ~empty_o;
      refill      = ~out_valid_q | pop;
      ram_take    = refill & (ram_cnt_q != '0);
      fall_thru   = refill & (ram_cnt_q == '0) & push;
      ram_we      = push & ~fall_thru;
      rd_ptr_next = rd_ptr_q + DEPTH_WIDTH'(ram_take);

      wr_ptr_d    = wr_ptr_q + DEPTH_WIDTH'(ram_we);
      rd_ptr_d    = rd_ptr_next;
      ram_cnt_d   = ram_cnt_q + CNT_WIDTH'(ram_we) - CNT_WIDTH'(ram_take);
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      byp_valid_d = ram_we & (wr_ptr_q == rd_ptr_next);
      byp_data_d  = byp_data_q;

      if (refill) begin
         out_valid_d = ram_take | fall_thru;
      end
      if (ram_take) begin
         out_data_d = byp_valid_q ? byp_data_q : ram_dout_b;
      end else if (fall_thru) begin
         out_data_d = wr_data_i;
      end
      if (byp_valid_d) begin
         byp_data_d = wr_data_i;
      end

      if (flush_i) begin
         ram_we      = 1'b0;
         rd_ptr_next = '0;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         ram_cnt_d   = '0;
         out_valid_d = 1'b0;
         out_data_d  = out_data_q;
         byp_valid_d = 1'b0;
         byp_data_d  = byp_data_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         ram_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         byp_valid_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         ram_cnt_q   <= ram_cnt_d;
         out_valid_q <= out_valid_d;
         byp_valid_q <= byp_valid_d;
      end
   end

   // Data registers need no reset; their contents are qualified by the valid flags.
   always_ff @(posedge clk) begin
      out_data_q <= out_data_d;
      byp_data_q <= byp_data_d;
   end

   mor1kx_dpram_fifo_ram #(
      .ADDR_WIDTH (DEPTH_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .clk      (clk),
      .we_a_i   (ram_we),
      .addr_a_i (wr_ptr_q),
      .din_a_i  (wr_data_i),
      .dout_a_o (),
      .we_b_i   (1'b0),
      .addr_b_i (rd_ptr_next),
      .din_b_i  ({DATA_WIDTH{1'b0}}),
      .dout_b_o (ram_dout_b)
   );

endmodule

// File: tb/tb_mor1kx_dpram_fifo.sv
// Scoreboard bench for mor1kx_dpram_fifo: the queue model holds expected contents,
// a negedge monitor checks status every cycle and the head on each accepted pop.
module tb_mor1kx_dpram_fifo;

   localparam int unsigned DW  = 4;
   localparam int unsigned XW  = 32;
   localparam int          CAP = (1 << DW) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush_i = 1'b0;
   logic          wr_i = 1'b0;
   logic [XW-1:0] wr_data_i = '0;
   logic          full_o;
   logic          rd_i = 1'b0;
   logic [XW-1:0] rd_data_o;
   logic          empty_o;
   logic [DW:0]   count_o;

   logic [XW-1:0] sb[$];
   int            total = 0;
   int            bad = 0;
   bit            mon_en = 1'b0;

   always #5 clk = ~clk;

   mor1kx_dpram_fifo dut (
      .clk       (clk),
      .rst       (rst),
      .flush_i   (flush_i),
      .wr_i      (wr_i),
      .wr_data_i (wr_data_i),
      .full_o    (full_o),
      .rd_i      (rd_i),
      .rd_data_o (rd_data_o),
      .empty_o   (empty_o),
      .count_o   (count_o)
   );

   task automatic chk(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Status every cycle, then head data when the model says a pop is accepted.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("count", XW'(count_o), XW'(sb.size()));
         chk("empty", XW'(empty_o), XW'(sb.size() == 0));
         chk("full",  XW'(full_o),  XW'(sb.size() == CAP));
         if (rd_i && !flush_i && !rst && sb.size() > 0) begin
            logic [XW-1:0] exp_d;
            exp_d = sb.pop_front();
            chk("head", rd_data_o, exp_d);
         end
      end
   end

   // One clock of stimulus; the model takes the push after the edge.
   task automatic cyc(input logic w, input logic [XW-1:0] d, input logic r, input logic f);
      int pre;
      wr_i = w; wr_data_i = d; rd_i = r; flush_i = f;
      pre = sb.size();
      @(posedge clk);
      if (f || rst) sb.delete();
      else if (w && pre < CAP) sb.push_back(d);
      #1;
   endtask

   initial begin
      int wp, rp;
      // reset, then reads on an empty FIFO are ignored
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      mon_en = 1'b1;
      repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);

      // fall-through
      cyc(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);

      // fill, overflow attempt, drain
      for (int i = 0; i < CAP; i++) cyc(1'b1, XW'(i), 1'b0, 1'b0);
      cyc(1'b1, 32'h0000_DEAD, 1'b0, 1'b0);
      cyc(1'b1, 32'h0000_BEEF, 1'b1, 1'b0);
      for (int i = 0; i < CAP; i++) cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);

      // streaming with one-cycle pop lag, wraps the RAM pointers
      for (int i = 0; i < 40; i++) cyc(1'b1, 32'h5000_0000 + XW'(i), i > 0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);

      // collision: head held, RAM empty, push and pop together
      cyc(1'b1, 32'hC0DE_0001, 1'b0, 1'b0);
      cyc(1'b1, 32'hC0DE_0002, 1'b1, 1'b0);
      cyc(1'b1, 32'hC0DE_0003, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);

      // flush with concurrent push and pop
      for (int i = 0; i < 5; i++) cyc(1'b1, 32'hF000_0000 + XW'(i), 1'b0, 1'b0);
      cyc(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
      cyc(1'b1, 32'h0000_1234, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);

      // random phases with varying push/pop pressure and rare flushes
      wp = 50; rp = 50;
      for (int i = 0; i < 3000; i++) begin
         if (i % 100 == 0) begin
            wp = int'($urandom_range(10, 95));
            rp = int'($urandom_range(10, 95));
         end
         cyc(int'($urandom_range(0, 99)) < wp, $urandom,
             int'($urandom_range(0, 99)) < rp, $urandom_range(0, 299) == 0);
      end
      repeat (CAP + 1) cyc(1'b0, '0, 1'b1, 1'b0);

      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
